// File: rtl/ascii_pkg.sv
// Purpose: shared ASCII constants and receive-parser state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: CR/LF terminators, hex digit range bounds (also used by the
// TicToc binary-to-ASCII converter), and the parser state enum.
package ascii_pkg;

  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;

  localparam logic [7:0] ASCII_DIGIT_LO = 8'h30;  // '0'
  localparam logic [7:0] ASCII_DIGIT_HI = 8'h39;  // '9'
  localparam logic [7:0] ASCII_UPPER_LO = 8'h41;  // 'A'
  localparam logic [7:0] ASCII_UPPER_HI = 8'h46;  // 'F'
  localparam logic [7:0] ASCII_LOWER_LO = 8'h61;  // 'a'
  localparam logic [7:0] ASCII_LOWER_HI = 8'h66;  // 'f'

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    DISCARD = 2'd2
  } rxState_t;

endpackage

// File: rtl/hex_char_decode.sv
// Purpose: classify one ASCII character as hex digit / line terminator / other.
// Latency: purely combinational.
// Backpressure: none.
// Ports: asciiChar (8-bit character in), is_hex, is_term, nibble (value 0-15,
// zero when the character is not a hex digit).
module hex_char_decode
  import ascii_pkg::*;
(
  input  logic [7:0] asciiChar,
  output logic       is_hex,
  output logic       is_term,
  output logic [3:0] nibble
);

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (asciiChar >= ASCII_DIGIT_LO && asciiChar <= ASCII_DIGIT_HI) begin
      is_hex = 1'b1;
      nibble = asciiChar[3:0];
    end else if ((asciiChar >= ASCII_UPPER_LO && asciiChar <= ASCII_UPPER_HI) ||
                 (asciiChar >= ASCII_LOWER_LO && asciiChar <= ASCII_LOWER_HI)) begin
      // 'A'/'a' have low nibble 1, so adding 9 maps them onto 10.
      is_hex = 1'b1;
      nibble = asciiChar[3:0] + 4'd9;
    end
  end

  assign is_term = (asciiChar == ASCII_CR) || (asciiChar == ASCII_LF);

endmodule

// File: rtl/ascii_hex_rx_parser.sv
// Purpose: assemble a CR/LF-terminated line of ASCII hex digits into a word.
// Latency: Val_ready/Val_Arr and Val_error appear one cycle after the strobe.
// Backpressure: none; every strobed character is consumed, back-to-back ok.
// Ports: Clk, Reset (sync, active-high), RX_ready/RX_data (character strobe),
// Val_Arr (last committed word), Val_ready (commit pulse), Val_error
// (malformed-line pulse), Busy (line in progress).
module ascii_hex_rx_parser
  import ascii_pkg::*;
#(
  parameter  int NDIGITS = 4,
  localparam int WIDTH   = 4 * NDIGITS
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             RX_ready,
  input  logic [7:0]       RX_data,
  output logic [WIDTH-1:0] Val_Arr,
  output logic             Val_ready,
  output logic             Val_error,
  output logic             Busy
);

  localparam int CW = $clog2(NDIGITS + 1);

  rxState_t         state, stateNext;
  logic [WIDTH-1:0] acc, accNext;
  logic [CW-1:0]    count, countNext;
  logic [WIDTH-1:0] valArrNext;
  logic             readyNext, errorNext;

  logic             isHex, isTerm;
  logic [3:0]       nibble;

  hex_char_decode uDecode (
    .asciiChar (RX_data),
    .is_hex    (isHex),
    .is_term   (isTerm),
    .nibble    (nibble)
  );

  always_comb begin
    stateNext  = state;
    accNext    = acc;
    countNext  = count;
    valArrNext = Val_Arr;
    readyNext  = 1'b0;
    errorNext  = 1'b0;

    if (RX_ready) begin
      case (state)
        IDLE: begin
          // A bare terminator is an empty line (e.g. the LF of CR-LF): ignore it.
          if (isHex) begin
            accNext   = WIDTH'(nibble);
            countNext = CW'(1);
            stateNext = ACCUM;
          end else if (!isTerm) begin
            errorNext = 1'b1;
            stateNext = DISCARD;
          end
        end
        ACCUM: begin
          if (isTerm) begin
            valArrNext = acc;
            readyNext  = 1'b1;
            accNext    = '0;
            countNext  = '0;
            stateNext  = IDLE;
          end else if (isHex && count != CW'(NDIGITS)) begin
            accNext   = (acc << 4) | WIDTH'(nibble);
            countNext = count + CW'(1);
          end else begin
            // Illegal character or one digit too many; acc is left untouched.
            errorNext = 1'b1;
            stateNext = DISCARD;
          end
        end
        DISCARD: begin
          // Only one error pulse per line; wait silently for the terminator.
          if (isTerm) begin
            accNext   = '0;
            countNext = '0;
            stateNext = IDLE;
          end
        end
        default: begin
          stateNext = IDLE;
          accNext   = '0;
          countNext = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      Val_Arr   <= '0;
      Val_ready <= 1'b0;
      Val_error <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      state     <= stateNext;
      acc       <= accNext;
      count     <= countNext;
      Val_Arr   <= valArrNext;
      Val_ready <= readyNext;
      Val_error <= errorNext;
      // Registered alongside state so Busy tracks (state != IDLE) exactly.
      Busy      <= (stateNext != IDLE);
    end
  end

endmodule

// File: doc/ascii_hex_rx_parser.md
Name: ascii_hex_rx_parser

Overview:
- Receive-side counterpart of the TicToc binary-to-ASCII converter.
- Consumes ASCII characters from the UART receiver, one per strobe.
- Assembles a line of hex digits, terminated by CR or LF, into a binary word.
- Presents the word with a one-cycle ready pulse to the command/compare logic; malformed lines are flagged and discarded.

Parameters:
- NDIGITS, 4, maximum hex digits per line. The derived localparam WIDTH = 4*NDIGITS is the output word width.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- RX_ready  input  1  one-cycle strobe: RX_data holds a valid character this cycle. Each high cycle is one character; back-to-back strobes are legal.
- RX_data  input  8  received ASCII character.
- Val_Arr  output  WIDTH  last committed value; holds until the next commit.
- Val_ready  output  1  one-cycle pulse when Val_Arr has just been updated.
- Val_error  output  1  one-cycle pulse on the offending character of a malformed line.
- Busy  output  1  high while a line is partially received (state != IDLE).

Behaviour:
- Reset values: Val_Arr=0, Val_ready=0, Val_error=0, Busy=0, state=IDLE, accumulator=0, digit count=0. A reset mid-line abandons the line with no pulse.
- Character classes:
  - hex digit: '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46), 'a'-'f' (0x61-0x66), mapped to nibble 0-15.
  - terminator: CR 0x0D or LF 0x0A.
  - anything else (including space): illegal.
- Cycles where RX_ready=0 change no state.
- States are IDLE, ACCUM and DISCARD. Transitions on a strobed character:
  - IDLE, hex: acc <= {0, nibble}, count <= 1, go to ACCUM.
  - IDLE, terminator: ignored, stay in IDLE, no pulse. The empty line covers the LF of CR-LF.
  - IDLE, illegal: Val_error pulse, go to DISCARD.
  - ACCUM, hex, count < NDIGITS: acc <= {acc[WIDTH-5:0], nibble}, count++.
  - ACCUM, hex, count == NDIGITS: overflow. Val_error pulse, go to DISCARD; acc is not modified.
  - ACCUM, terminator: Val_Arr <= acc, Val_ready pulse, clear acc and count, go to IDLE.
  - ACCUM, illegal: Val_error pulse, go to DISCARD.
  - DISCARD, terminator: clear acc and count, go to IDLE, no pulse.
  - DISCARD, any other character: ignored, no further error pulses for that line.
- Width rules:
  - Short lines are right-aligned and zero-extended: "2A" gives 0x002A.
  - Exactly NDIGITS digits fill the word.
- Latency:
  - Val_ready and the new Val_Arr are visible the cycle after the terminator strobe is sampled.
  - Val_error is visible the cycle after the offending strobe.
- Val_ready and Val_error are never high in the same cycle; each is high for exactly one cycle per event.
- Busy is a registered decode of state.
- A new character strobed in the cycle Val_ready is high is processed normally, so full back-to-back throughput is supported.

Decomposition:
- Shared package (ascii_pkg):
  - constants ASCII_CR=8'h0D and ASCII_LF=8'h0A;
  - digit range bounds;
  - state encoding IDLE/ACCUM/DISCARD.
  - The TicToc converter reuses the same digit constants.
- One combinational sub-module, hex_char_decode:
  - input: 8-bit char;
  - outputs: is_hex, is_term, nibble[3:0].
  - It is unit-testable on its own against all 256 codes.

Test Plan:
- Strobe '1','2','3','4',CR on consecutive cycles -> Val_ready pulses once, one cycle after CR, with Val_Arr=0x1234; Busy high from the cycle after '1' until the cycle after CR.
- 'a','F',LF with 3 idle cycles between each strobe -> Val_Arr=0x00AF, a single Val_ready pulse.
- '1','2','3','4','5',CR, then 'B','E','E','F',CR -> Val_error pulses once, after '5'; no Val_ready for the first line; the second line yields Val_Arr=0xBEEF; Val_Arr keeps its prior value in between.
- CR,LF, then '7',CR,LF -> exactly one Val_ready pulse, with Val_Arr=0x0007; the empty lines produce no pulse.
- '1','G','2',CR -> Val_error after 'G', no Val_ready, returns to IDLE after CR; a following '9',CR gives 0x0009.
- '1','2', then Reset high for 1 cycle, then '3','4',CR -> all outputs 0 after Reset; the line commits 0x0034.
